// File: rtl/classifier_pkg.sv
// rtl/classifier_pkg.sv - shared types and width helper for the classifier mask-energy stage
// CLASSIFIER_ENERGY_SATURATE_EN narrows the accumulator to BIT_WIDTH with saturating adds.
package classifier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mask_energy_state_t;

    // Wide enough that N_SAMPLES full-scale magnitudes cannot wrap.
    function automatic int acc_width(input int bit_width, input int n_samples);
`ifdef CLASSIFIER_ENERGY_SATURATE_EN
        acc_width = bit_width + 0 * n_samples;
`else
        acc_width = bit_width + $clog2(n_samples);
`endif
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(32, 8);

endpackage

// File: rtl/classifier_mask_energy_accum.sv
// rtl/classifier_mask_energy_accum.sv - masked magnitude accumulator with clear/enable
// CLASSIFIER_ENERGY_SATURATE_EN clamps each add at all-ones instead of wrapping.
module classifier_mask_energy_accum #(
    parameter int BIT_WIDTH = 32,
    parameter int ACC_W     = 35
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 mask_bit,
    input  logic [BIT_WIDTH-1:0] mag,
    output logic [ACC_W-1:0]     acc
);

    logic [ACC_W-1:0] acc_next;

`ifdef CLASSIFIER_ENERGY_SATURATE_EN
    logic [ACC_W:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + (ACC_W + 1)'(mag);
        acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_next = acc + ACC_W'(mag);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc <= '0;
        end else if (en && mask_bit) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/classifier_mask_energy.sv
// rtl/classifier_mask_energy.sv - walks one frame of bins, sums masked magnitudes, compares to threshold
// CLASSIFIER_ENERGY_SATURATE_EN selects the saturating BIT_WIDTH accumulator.
module classifier_mask_energy
    import classifier_pkg::*;
#(
    parameter  int BIT_WIDTH  = 32,
    parameter  int DECIMAL_PT = 16,
    parameter  int N_SAMPLES  = 8,
    localparam int ACC_W      = acc_width(BIT_WIDTH, N_SAMPLES)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_mag,
    input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_mask,
    input  logic [BIT_WIDTH-1:0]           recv_thresh,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic                           send_msg,
    output logic [ACC_W-1:0]               send_energy,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    if (N_SAMPLES < 2) begin : g_bad_n
        $error("N_SAMPLES must be at least 2");
    end
    if (DECIMAL_PT > BIT_WIDTH) begin : g_bad_pt
        $error("DECIMAL_PT must not exceed BIT_WIDTH");
    end

    mask_energy_state_t   state;
    logic [IDX_W-1:0]     idx;
    logic [BIT_WIDTH-1:0] mag_q [N_SAMPLES];
    logic [N_SAMPLES-1:0] mask_q;
    logic [BIT_WIDTH-1:0] thresh_q;
    logic [ACC_W-1:0]     acc;
    logic                 accept;
    logic                 unused_mask_bits;

    assign unused_mask_bits = ^recv_mask;
    assign accept           = (state == IDLE) && recv_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            mask_q   <= '0;
            thresh_q <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                mag_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val) begin
                        for (int i = 0; i < N_SAMPLES; i++) begin
                            mag_q[i]  <= recv_mag[i*BIT_WIDTH +: BIT_WIDTH];
                            mask_q[i] <= recv_mask[i*BIT_WIDTH];
                        end
                        thresh_q <= recv_thresh;
                        idx      <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (send_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    classifier_mask_energy_accum #(
        .BIT_WIDTH (BIT_WIDTH),
        .ACC_W     (ACC_W)
    ) u_accum (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (accept),
        .en       (state == CALC),
        .mask_bit (mask_q[idx]),
        .mag      (mag_q[idx]),
        .acc      (acc)
    );

    // Both operands carry DECIMAL_PT fractional bits, so a plain unsigned compare suffices.
    assign recv_rdy    = (state == IDLE);
    assign send_val    = (state == DONE);
    assign send_energy = acc;
    assign send_msg    = (state == DONE) && (acc >= ACC_W'(thresh_q));

endmodule

// File: tb/tb_classifier_mask_energy.sv
// tb/tb_classifier_mask_energy.sv - scoreboard bench for classifier_mask_energy
module tb_classifier_mask_energy;

    localparam int BW = 32;
    localparam int NS = 8;
`ifdef CLASSIFIER_ENERGY_SATURATE_EN
    localparam int AW = BW;
`else
    localparam int AW = BW + 3;
`endif

    logic               clk;
    logic               reset_n;
    logic [BW*NS-1:0]   recv_mag;
    logic [BW*NS-1:0]   recv_mask;
    logic [BW-1:0]      recv_thresh;
    logic               recv_val;
    logic               recv_rdy;
    logic               send_msg;
    logic [AW-1:0]      send_energy;
    logic               send_val;
    logic               send_rdy;

    classifier_mask_energy dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .recv_mag    (recv_mag),
        .recv_mask   (recv_mask),
        .recv_thresh (recv_thresh),
        .recv_val    (recv_val),
        .recv_rdy    (recv_rdy),
        .send_msg    (send_msg),
        .send_energy (send_energy),
        .send_val    (send_val),
        .send_rdy    (send_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] energy;
        logic          msg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && send_val && send_rdy) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 64'(send_energy), 64'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                check("sb_energy", 64'(send_energy), 64'(mon_e.energy));
                check("sb_msg", 64'(send_msg), 64'(mon_e.msg));
            end
        end
    end

    task automatic accept(input logic [BW*NS-1:0] mags, input logic [NS-1:0] mbits,
                          input logic [BW-1:0] th, input logic [AW-1:0] e_energy,
                          input logic e_msg, input bit push);
        int   n;
        logic [BW-1:0] word;
        exp_t e;
        n = 0;
        while (!recv_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!recv_rdy) check("accept_timeout", 64'(recv_rdy), 64'h1);
        recv_mag = mags;
        for (int i = 0; i < NS; i++) begin
            word = 32'hFFFF_FFFE;
            word[0] = mbits[i];
            recv_mask[i*BW +: BW] = word;
        end
        recv_thresh = th;
        recv_val    = 1'b1;
        if (push) begin
            e.energy = e_energy;
            e.msg    = e_msg;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        recv_val    = 1'b0;
        recv_mag    = ~mags;
        recv_mask   = ~recv_mask;
        recv_thresh = ~th;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!send_val && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    logic [BW*NS-1:0] ones, ramp, full;
    int c;

    initial begin
        for (int i = 0; i < NS; i++) begin
            ones[i*BW +: BW] = 32'h0001_0000;
            ramp[i*BW +: BW] = 32'(i) << 16;
            full[i*BW +: BW] = 32'hFFFF_FFFF;
        end
        reset_n = 1'b0; send_rdy = 1'b1; recv_val = 1'b0;
        recv_mag = '0; recv_mask = '0; recv_thresh = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_recv_rdy", 64'(recv_rdy), 64'h1);
        check("rst_send_val", 64'(send_val), 64'h0);
        check("rst_send_msg", 64'(send_msg), 64'h0);
        check("rst_send_energy", 64'(send_energy), 64'h0);

        accept(ones, 8'hF0, 32'h0004_0000, AW'(64'h4_0000), 1'b1, 1'b1);
        wait_valid(c);
        check("latency_first", 64'(c), 64'd8);
        accept(ones, 8'hF0, 32'h0004_0001, AW'(64'h4_0000), 1'b0, 1'b1);
        wait_valid(c);
        accept(ones, 8'h00, 32'h0, AW'(64'h0), 1'b1, 1'b1);
        wait_valid(c);
        accept(ones, 8'h00, 32'h1, AW'(64'h0), 1'b0, 1'b1);
        wait_valid(c);
        accept(ramp, 8'b1010_0101, 32'h000E_0000, AW'(64'hE_0000), 1'b1, 1'b1);
        wait_valid(c);
        accept(ramp, 8'b1010_0101, 32'h000E_0001, AW'(64'hE_0000), 1'b0, 1'b1);
        wait_valid(c);

        accept(ones, 8'hF0, 32'h0004_0000, AW'(64'h4_0000), 1'b1, 1'b1);
        send_rdy = 1'b0;
        wait_valid(c);
        check("stall_latency", 64'(c), 64'd8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_send_val", 64'(send_val), 64'h1);
            check("stall_energy", 64'(send_energy), 64'h4_0000);
            check("stall_msg", 64'(send_msg), 64'h1);
            check("stall_recv_rdy", 64'(recv_rdy), 64'h0);
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        check("post_hs_recv_rdy", 64'(recv_rdy), 64'h1);
        check("post_hs_send_val", 64'(send_val), 64'h0);

        accept(ones, 8'hFF, 32'h0, AW'(64'h0), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst_send_val", 64'(send_val), 64'h0);
        check("midrst_energy", 64'(send_energy), 64'h0);
        check("midrst_recv_rdy", 64'(recv_rdy), 64'h1);
        check("midrst_msg", 64'(send_msg), 64'h0);
        accept(ones, 8'hFF, 32'h0008_0000, AW'(64'h8_0000), 1'b1, 1'b1);
        wait_valid(c);
        check("latency_after_rst", 64'(c), 64'd8);

`ifdef CLASSIFIER_ENERGY_SATURATE_EN
        accept(full, 8'hFF, 32'hFFFF_FFFF, AW'(64'hFFFF_FFFF), 1'b1, 1'b1);
`else
        accept(full, 8'hFF, 32'hFFFF_FFFF, AW'(64'h7_FFFF_FFF8), 1'b1, 1'b1);
`endif
        wait_valid(c);
        @(posedge clk); #1;
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/classifier_mask_energy.md
# classifier_mask_energy

Sequential consumer of the highpass per-bin valid mask. Accepts one frame of `N_SAMPLES` fixed-point magnitudes together with the mask produced from the matching frequency bins. Walks the bins one per cycle, summing magnitudes whose mask bit is set, and compares the sum against a programmable threshold. Emits a 1-bit classification over a val/rdy handshake. Sits between the highpass mask stage and the classifier output register.

## Interface
- `BIT_WIDTH`, 32: width of each magnitude, mask word and threshold.
- `DECIMAL_PT`, 16: fractional bits of magnitudes and threshold (unsigned Qm.n).
- `N_SAMPLES`, 8: bins per frame; must be ≥ 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `recv_mag` input `BIT_WIDTH` x `N_SAMPLES`: bin magnitudes.
- `recv_mask` input `BIT_WIDTH` x `N_SAMPLES`: highpass valid words; only bit 0 is used, the rest are ignored.
- `recv_thresh` input `BIT_WIDTH`: energy threshold.
- `recv_val` input 1: input frame valid.
- `recv_rdy` output 1: block can accept a frame.
- `send_msg` output 1: 1 if the masked energy is ≥ the threshold.
- `send_energy` output `ACC_W`: final masked sum.
- `send_val` output 1: result valid.
- `send_rdy` input 1: downstream accepts the result.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `recv_rdy`=1.
  - On `recv_val`&`recv_rdy`, register all magnitudes, mask bits and the threshold; clear the accumulator and the index; go to CALC.
- **CALC:**
  - Each cycle: `acc += mask[idx] ? mag[idx] : 0`, then `idx++`.
  - After the cycle that processes `idx == N_SAMPLES-1`, go to DONE.
  - `recv_rdy`=0.
- **DONE:**
  - `send_val`=1, `send_energy`=acc, `send_msg`=(acc ≥ zero-extended threshold).
  - On `send_rdy`, go to IDLE.
  - Outputs stay stable while `send_val` is high and `send_rdy` is low.
- **Width:** `ACC_W` = `BIT_WIDTH` + clog2(`N_SAMPLES`). The sum cannot overflow. The comparison is unsigned and needs no decimal alignment, because both operands share `DECIMAL_PT`.
- **Input stability:** inputs are sampled only at the accept edge. Later changes to `recv_*` have no effect on the frame in progress.
- **Empty mask:** all mask bits 0 → acc=0. `send_msg`=1 only when the threshold is 0.
- **No overlap:** a new frame is not accepted in the same cycle as a send handshake. `recv_rdy` rises the cycle after the handshake.
- **Reset:** `reset_n`=0 at an edge, including mid-CALC or mid-DONE:
  - State goes to IDLE; acc, idx and the captured registers clear.
  - `send_val`=0, `send_msg`=0, `send_energy`=0, `recv_rdy`=1 from the next cycle.
  - The in-flight frame is discarded with no output.

## Timing
- Accept edge is E0. CALC occupies cycles E0+1 … E0+`N_SAMPLES`. `send_val` is first high in cycle E0+`N_SAMPLES`+1.
- Minimum frame period, with `send_rdy` tied high: `N_SAMPLES`+2 cycles.
- `recv_rdy` and `send_val` are decoded from the state register only. There is no combinational path from `send_rdy` or `recv_val` to any output.

## Configuration
- `CLASSIFIER_ENERGY_SATURATE_EN` defined:
  - Accumulator and `send_energy` are `BIT_WIDTH` wide.
  - Each add saturates at all-ones instead of wrapping. Once saturated, the accumulator stays at all-ones for the rest of the frame.
- Undefined: the widened `ACC_W` accumulator with no saturation logic.

## Structure
- **Shared package `classifier_pkg`:**
  - State enum `mask_energy_state_t` (IDLE/CALC/DONE).
  - `ACC_W` computed from `BIT_WIDTH` and `N_SAMPLES`.
- **Sub-module:** `classifier_mask_energy_accum`, holding the accumulator register, masked add and optional saturation, with clear/enable inputs.
- The top level holds the FSM, index counter, capture registers and comparator.

## Test plan
- 1.0 = 0x0001_0000 (`N_SAMPLES`=8, `DECIMAL_PT`=16).
- Mags all 1.0, mask 0b11110000 (bins 4–7 set), thresh 4.0 → `send_energy`=0x4_0000, `send_msg`=1, `send_val` high in cycle E0+9.
- Same frame, thresh 4.0+1 LSB (0x4_0001) → `send_msg`=0.
- Mask all 0, thresh 0 → `send_energy`=0, `send_msg`=1. Same frame with thresh 1 → `send_msg`=0.
- Hold `send_rdy`=0 for 5 cycles in DONE → outputs stable and `recv_rdy`=0 throughout. After the handshake, `recv_rdy`=1 the next cycle.
- Assert `reset_n`=0 at CALC idx=3 → next cycle IDLE, `send_val`=0, `send_energy`=0. The following frame computes correctly.
- All mags 0xFFFF_FFFF, mask all 1:
  - Without the macro: `send_energy`=0x7_FFFF_FFF8.
  - With `CLASSIFIER_ENERGY_SATURATE_EN`: `send_energy`=0xFFFF_FFFF.
